// File: rtl/linear_layer_fifo_pkg.sv
// Shared definitions for the linear-layer token FIFOs.
//   PTR_EMPTY     : head-pointer value meaning "no tokens" (all ones, i.e. -1)
//   ptr_width()   : width of the signed head pointer and of the occupancy count
//   flag_state_e  : controller state, one-to-one with the full/empty flag pair
package linear_layer_fifo_pkg;

    localparam int PTR_EMPTY = -1;

    // One extra bit over the SRL address so the pointer can sit at -1 and
    // the count can reach DEPTH when DEPTH == 2**ADDR_WIDTH.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } flag_state_e;

endpackage

// File: rtl/linear_layer_start_token_fifo_srl.sv
// Unreset shift-register storage for the start-token FIFO.
//   clk  : clock, storage shifts on the rising edge
//   we   : shift enable; entry[0] <= din, entry[i+1] <= entry[i]
//   addr : entry index presented on dout (the controller's head pointer)
//   din  : token shifted in
//   dout : entry[addr], combinational
module linear_layer_start_token_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i+1] <= mem[i];
            end
        end
    end

    // When empty the pointer's low bits are all ones, which can fall outside
    // a DEPTH smaller than 2**ADDR_WIDTH; the output is don't-care then.
    always_comb begin
        dout = '0;
        if (int'(addr) < DEPTH) begin
            dout = mem[addr];
        end
    end

endmodule

// File: rtl/linear_layer_start_token_fifo.sv
// Start-token FIFO between two dataflow processes of the i4xi4 linear layer.
// The producer pushes one token per launched task, the consumer pops one per
// started task. Storage is an unreset SRL; pointer, flags and count reset
// asynchronously.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   if_full_n                    : 1 = space available (registered)
//   if_write_ce, if_write, if_din: producer enable, push request, token
//   if_empty_n                   : 1 = token available (registered)
//   if_read_ce, if_read          : consumer enable, pop request
//   if_dout                      : head token, valid only while if_empty_n=1
//   if_num_data                  : registered occupancy, 0..DEPTH
//   dbg_state                    : controller state (EMPTY/PARTIAL/FULL)
// Handshake: a push happens when if_write & if_write_ce & if_full_n, a pop
// when if_read & if_read_ce & if_empty_n; requests against the wrong flag are
// dropped with no side effect.
module linear_layer_start_token_fifo
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data,
    output flag_state_e           dbg_state
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic signed [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    flag_state_e          state_q, state_d;
    logic                 push, pop;

    // Flags decode straight from the state register, so there is no
    // combinational path from the request inputs to either flag.
    assign if_full_n   = (state_q != ST_FULL);
    assign if_empty_n  = (state_q != ST_EMPTY);
    assign if_num_data = cnt_q;
    assign dbg_state   = state_q;

    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= PW'(PTR_EMPTY);
            cnt_q   <= '0;
            state_q <= ST_EMPTY;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Simultaneous push and pop leaves pointer, count and state alone: the
    // shift moves the next-oldest token under the unchanged pointer.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case ({push, pop})
            2'b10: begin
                ptr_d   = ptr_q + PW'(1);
                cnt_d   = cnt_q + PW'(1);
                state_d = (ptr_q == PW'(DEPTH - 2)) ? ST_FULL : ST_PARTIAL;
            end
            2'b01: begin
                ptr_d   = ptr_q - PW'(1);
                cnt_d   = cnt_q - PW'(1);
                state_d = (ptr_q == '0) ? ST_EMPTY : ST_PARTIAL;
            end
            default: ;
        endcase
    end

    linear_layer_start_token_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .we   (push),
        .addr (ptr_q[ADDR_WIDTH-1:0]),
        .din  (if_din),
        .dout (if_dout)
    );

endmodule

// File: tb/tb_linear_layer_start_token_fifo.sv
module tb_linear_layer_start_token_fifo;
    import linear_layer_fifo_pkg::*;

    localparam int DW = 4;
    localparam int AW = 3;
    localparam int D  = 8;

    // clock / reset
    logic clk;
    logic reset_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main DUT (DEPTH=8)
    logic          write_ce, write, read_ce, read;
    logic [DW-1:0] din, dout;
    logic          full_n, empty_n;
    logic [AW:0]   num_data;
    flag_state_e   dbg_state;

    linear_layer_start_token_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_full_n   (full_n),
        .if_write_ce (write_ce),
        .if_write    (write),
        .if_din      (din),
        .if_empty_n  (empty_n),
        .if_read_ce  (read_ce),
        .if_read     (read),
        .if_dout     (dout),
        .if_num_data (num_data),
        .dbg_state   (dbg_state)
    );

    // small DUT (DEPTH=2)
    logic          write_ce2, write2, read_ce2, read2;
    logic [DW-1:0] din2, dout2;
    logic          full_n2, empty_n2;
    logic [1:0]    num_data2;
    flag_state_e   dbg_state2;

    linear_layer_start_token_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(2)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_full_n   (full_n2),
        .if_write_ce (write_ce2),
        .if_write    (write2),
        .if_din      (din2),
        .if_empty_n  (empty_n2),
        .if_read_ce  (read_ce2),
        .if_read     (read2),
        .if_dout     (dout2),
        .if_num_data (num_data2),
        .dbg_state   (dbg_state2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: a plain queue of tokens, capacity D
    logic [DW-1:0] exp_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            bit m_push, m_pop;
            m_push = write && write_ce && (exp_q.size() < D);
            m_pop  = read && read_ce && (exp_q.size() > 0);
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(din);
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (reset_n) begin
            int n;
            int st;
            n  = exp_q.size();
            st = (n == 0) ? 0 : ((n == D) ? 2 : 1);
            check("model_empty_n", 32'(empty_n), 32'(n != 0));
            check("model_full_n", 32'(full_n), 32'(n < D));
            check("model_num_data", 32'(num_data), 32'(n));
            check("model_state", 32'(dbg_state), 32'(st));
            if (n != 0) check("model_dout", 32'(dout), 32'(exp_q[0]));
        end
    end

    // driver tasks: each call starts at a falling edge and spans one cycle
    task automatic idle();
        write = 1'b0; read = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] v);
        write = 1'b1; write_ce = 1'b1; din = v; read = 1'b0;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic pop_expect(input logic [DW-1:0] v);
        check("pop_dout", 32'(dout), 32'(v));
        read = 1'b1; read_ce = 1'b1; write = 1'b0;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic push_pop_expect(input logic [DW-1:0] v, input logic [DW-1:0] head);
        check("pp_dout", 32'(dout), 32'(head));
        write = 1'b1; write_ce = 1'b1; din = v;
        read = 1'b1; read_ce = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
    endtask

    logic [DW-1:0] tok [8];

    initial begin
        reset_n = 1'b0;
        write_ce = 1'b1; write = 1'b0; din = '0; read_ce = 1'b1; read = 1'b0;
        write_ce2 = 1'b1; write2 = 1'b0; din2 = '0; read_ce2 = 1'b1; read2 = 1'b0;
        tok[0] = 4'h3; tok[1] = 4'h5; tok[2] = 4'h7; tok[3] = 4'h9;
        tok[4] = 4'hB; tok[5] = 4'hD; tok[6] = 4'hF; tok[7] = 4'h2;

        // 1: reset values, then idle
        #12;
        check("rst_full_n", 32'(full_n), 32'd1);
        check("rst_empty_n", 32'(empty_n), 32'd0);
        check("rst_num_data", 32'(num_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) idle();
        check("idle_empty_n", 32'(empty_n), 32'd0);
        check("idle_num_data", 32'(num_data), 32'd0);

        // 2: fill to full, overflow ignored, drain in order
        for (int i = 1; i <= 8; i++) push(DW'(i));
        check("fill_full_n", 32'(full_n), 32'd0);
        check("fill_num_data", 32'(num_data), 32'd8);
        push(4'h9);
        check("ovf_num_data", 32'(num_data), 32'd8);
        for (int i = 1; i <= 8; i++) pop_expect(DW'(i));
        check("drain_empty_n", 32'(empty_n), 32'd0);
        check("drain_full_n", 32'(full_n), 32'd1);

        // 3: three deep, then four simultaneous push+pop cycles
        for (int i = 0; i < 3; i++) push(tok[i]);
        for (int i = 0; i < 4; i++) begin
            push_pop_expect(tok[i+3], tok[i]);
            check("pp_num_data", 32'(num_data), 32'd3);
            check("pp_empty_n", 32'(empty_n), 32'd1);
            check("pp_full_n", 32'(full_n), 32'd1);
        end
        for (int i = 4; i < 7; i++) pop_expect(tok[i]);
        check("pp_drained", 32'(num_data), 32'd0);

        // 4: pop while empty, push with write_ce low
        pop_expect(dout);  // head is don't-care; the pop itself must be ignored
        check("uf_num_data", 32'(num_data), 32'd0);
        check("uf_empty_n", 32'(empty_n), 32'd0);
        write = 1'b1; write_ce = 1'b0; din = 4'h6;
        @(negedge clk);
        write = 1'b0; write_ce = 1'b1;
        check("ce0_num_data", 32'(num_data), 32'd0);
        check("ce0_empty_n", 32'(empty_n), 32'd0);

        // 5: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) push(tok[i]);
        check("pre_rst_num", 32'(num_data), 32'd5);
        #3 reset_n = 1'b0;
        #1;
        check("arst_full_n", 32'(full_n), 32'd1);
        check("arst_empty_n", 32'(empty_n), 32'd0);
        check("arst_num_data", 32'(num_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        push(4'hA);
        check("post_rst_dout", 32'(dout), 32'hA);
        check("post_rst_num", 32'(num_data), 32'd1);
        pop_expect(4'hA);

        // 6: DEPTH=2 instance, push+pop while full pops only
        write2 = 1'b1; din2 = 4'h1;
        @(negedge clk);
        din2 = 4'h2;
        @(negedge clk);
        write2 = 1'b0;
        check("d2_full_n", 32'(full_n2), 32'd0);
        check("d2_num", 32'(num_data2), 32'd2);
        check("d2_head", 32'(dout2), 32'h1);
        write2 = 1'b1; din2 = 4'h3; read2 = 1'b1;
        @(negedge clk);
        write2 = 1'b0; read2 = 1'b0;
        check("d2_pp_num", 32'(num_data2), 32'd1);
        check("d2_pp_full_n", 32'(full_n2), 32'd1);
        check("d2_pp_dout", 32'(dout2), 32'h2);
        read2 = 1'b1;
        @(negedge clk);
        read2 = 1'b0;
        check("d2_empty_n", 32'(empty_n2), 32'd0);

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
